// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: two-digit seven-segment scan controller for digit
// positions 4 (tens) and 5 (ones). It arbitrates between a continuous primary
// value (a_val) and a timed overlay value (b_val) through a req/ack handshake.
// The shown value is latched once per refresh pair, so the two digits of a
// pair always come from the same value.
// Optional feature macro: SEG_BLANK_LEADING_ZERO_EN blanks the tens digit
// when the shown value is 0..9.

module seg_scan_arbiter #(
  parameter int SCAN_DIV    = 50000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] a_val,
  input  logic [6:0] b_val,
  input  logic       b_req,
  output logic       b_ack,
  output logic       b_busy,
  output logic [6:0] disp,
  output logic [5:0] dig
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  localparam logic [0:0] SHOW_A = 1'b0;
  localparam logic [0:0] SHOW_B = 1'b1;

  localparam logic SLOT_TENS = 1'b0;
  localparam logic SLOT_ONES = 1'b1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [5:0] DIG_TENS  = 6'b101111;
  localparam logic [5:0] DIG_ONES  = 6'b011111;
  localparam logic [5:0] DIG_OFF   = 6'b111111;

  logic [0:0]    state;
  logic [HW-1:0] hold_cnt;
  logic [6:0]    ovl;
  logic [SW-1:0] scan_cnt;
  logic          slot;
  logic          primed;
  logic [6:0]    cur;
  logic [6:0]    src_val;
  logic [6:0]    seg_val;
  logic [5:0]    dig_val;

  function automatic logic [6:0] digit_pattern(input logic [6:0] d);
    case (d)
      7'd0:    return 7'b1000000;
      7'd1:    return 7'b1111001;
      7'd2:    return 7'b0100100;
      7'd3:    return 7'b0110000;
      7'd4:    return 7'b0011001;
      7'd5:    return 7'b0010010;
      7'd6:    return 7'b0000010;
      7'd7:    return 7'b1111000;
      7'd8:    return 7'b0000000;
      7'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  // Source FSM: any request is accepted (also on the expiry cycle); otherwise the overlay times out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SHOW_A;
      hold_cnt <= '0;
      ovl      <= '0;
      b_ack    <= 1'b0;
      b_busy   <= 1'b0;
    end else begin
      b_ack <= 1'b0;
      if (b_req) begin
        state    <= SHOW_B;
        ovl      <= b_val;
        hold_cnt <= HOLD_LOAD;
        b_ack    <= 1'b1;
        b_busy   <= 1'b1;
      end else if (state == SHOW_B) begin
        if (hold_cnt == '0) begin
          state  <= SHOW_A;
          b_busy <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
      end
    end
  end

  // Value source chosen at the moment the tens slot is (re)entered.
  always_comb begin
    src_val = (state == SHOW_B) ? ovl : a_val;
  end

  // Scan divider and slot toggle; cur reloads only when a new tens slot begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      slot     <= SLOT_TENS;
      primed   <= 1'b0;
      cur      <= '0;
    end else if (!primed) begin
      primed <= 1'b1;
      cur    <= src_val;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      slot     <= ~slot;
      if (slot == SLOT_ONES) begin
        cur <= src_val;
      end
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  // Segment decode of the latched value for the current slot.
  always_comb begin
    seg_val = SEG_DASH;
    dig_val = (slot == SLOT_TENS) ? DIG_TENS : DIG_ONES;
    if (cur > 7'd99) begin
      seg_val = SEG_DASH;
    end else if (slot == SLOT_TENS) begin
`ifdef SEG_BLANK_LEADING_ZERO_EN
      if (cur <= 7'd9) begin
        seg_val = SEG_BLANK;
      end else begin
        seg_val = digit_pattern(cur / 7'd10);
      end
`else
      seg_val = digit_pattern(cur / 7'd10);
`endif
    end else begin
      seg_val = digit_pattern(cur % 7'd10);
    end
  end

  // Registered display drive; stays dark until the first value has been latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp <= SEG_BLANK;
      dig  <= DIG_OFF;
    end else if (primed) begin
      disp <= seg_val;
      dig  <= dig_val;
    end
  end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// tb_seg_scan_arbiter: directed and randomized checks of seg_scan_arbiter
// with SCAN_DIV=4 and HOLD_CYCLES=20. The reference model works in terms of
// "edges since reset release": which slot is shown, which value was selected
// at each tens-entry edge, and how long ago the last overlay was accepted.
// Honors SEG_BLANK_LEADING_ZERO_EN when the bundle is built with it.

module tb_seg_scan_arbiter;

  localparam int D    = 4;
  localparam int HOLD = 20;

`ifdef SEG_BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] a_val;
  logic [6:0] b_val;
  logic       b_req;
  logic       b_ack;
  logic       b_busy;
  logic [6:0] disp;
  logic [5:0] dig;

  seg_scan_arbiter #(.SCAN_DIV(D), .HOLD_CYCLES(HOLD)) dut (
    .clk    (clk),
    .reset  (reset),
    .a_val  (a_val),
    .b_val  (b_val),
    .b_req  (b_req),
    .b_ack  (b_ack),
    .b_busy (b_busy),
    .disp   (disp),
    .dig    (dig)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  localparam logic [6:0] TENS0 = BLANK ? 7'b1111111 : 7'b1000000;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n        = 0;
  int         last_acc = 0;
  bit         have_acc = 1'b0;
  logic [6:0] ovl_m    = '0;
  logic       exp_ack  = 1'b0;
  logic       exp_busy = 1'b0;
  int         sel_hist [0:4095];

  function automatic logic [6:0] exp_disp(input int cyc);
    int k;
    int v;
    if (cyc < 2) return 7'b1111111;
    k = (cyc - 2) / D;
    v = sel_hist[1 + 2 * D * (k / 2)];
    if (v > 99) return 7'b0111111;
    if (k % 2 == 0) begin
      if (BLANK && v < 10) return 7'b1111111;
      return seg_tab[4'(v / 10)];
    end
    return seg_tab[4'(v % 10)];
  endfunction

  function automatic logic [5:0] exp_dig(input int cyc);
    if (cyc < 2) return 6'b111111;
    return (((cyc - 2) / D) % 2 == 0) ? 6'b101111 : 6'b011111;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, n);
    end
  endtask

  // One clock: update the model from the pre-edge inputs, then compare all outputs.
  task automatic tick();
    int nn;
    bit active;
    if (reset) begin
      @(posedge clk);
      #1;
      n        = 0;
      have_acc = 1'b0;
      exp_ack  = 1'b0;
      exp_busy = 1'b0;
    end else begin
      nn     = n + 1;
      active = have_acc && (nn - last_acc <= HOLD);
      if (nn < 4096) sel_hist[nn] = active ? int'(ovl_m) : int'(a_val);
      if (b_req) begin
        last_acc = nn;
        have_acc = 1'b1;
        ovl_m    = b_val;
      end
      exp_ack = b_req;
      @(posedge clk);
      #1;
      n        = nn;
      exp_busy = have_acc && (n - last_acc < HOLD);
    end
    chk("model_disp", disp, exp_disp(n));
    chk("model_dig", {1'b0, dig}, {1'b0, exp_dig(n)});
    chk("model_ack", {6'b0, b_ack}, {6'b0, exp_ack});
    chk("model_busy", {6'b0, b_busy}, {6'b0, exp_busy});
  endtask

  // Advance until the requested digit enable appears, within a cycle budget.
  task automatic wait_slot(input logic [5:0] target, input int budget, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (dig === target) found = 1'b1;
    end
    chk(tag, {6'b0, found}, 7'd1);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    int acc;
    int burst;
    bit found;

    reset = 1'b1;
    a_val = 7'd42;
    b_val = 7'd0;
    b_req = 1'b0;
    repeat (3) tick();
    chk("reset_disp", disp, 7'b1111111);
    chk("reset_dig", {1'b0, dig}, 7'b0111111);

    reset = 1'b0;
    tick();
    chk("first_edge_dark", {1'b0, dig}, 7'b0111111);
    tick();
    chk("tens_42_dig", {1'b0, dig}, 7'b0101111);
    chk("tens_42_disp", disp, 7'b0011001);
    tick();
    a_val = 7'd17;
    repeat (3) tick();
    chk("ones_no_tear_dig", {1'b0, dig}, 7'b0011111);
    chk("ones_no_tear_disp", disp, 7'b0100100);
    repeat (4) tick();
    chk("tens_17", disp, 7'b1111001);
    repeat (4) tick();
    chk("ones_17", disp, 7'b1111000);

    $display("[TB] overlay");
    a_val = 7'd5;
    b_val = 7'd88;
    b_req = 1'b1;
    tick();
    acc   = n;
    b_req = 1'b0;
    b_val = 7'($urandom_range(0, 127));
    chk("ovl_ack", {6'b0, b_ack}, 7'd1);
    chk("ovl_busy", {6'b0, b_busy}, 7'd1);
    tick();
    chk("ovl_ack_single", {6'b0, b_ack}, 7'd0);
    found = 1'b0;
    while (!found && n < acc + 9) begin
      tick();
      found = (dig === 6'b101111) && (disp === 7'b0000000);
    end
    chk("ovl_visible", {6'b0, found}, 7'd1);
    wait_slot(6'b011111, D + 1, "ovl_ones_slot");
    chk("ovl_ones_8", disp, 7'b0000000);
    while (n < acc + 19) tick();
    chk("busy_held", {6'b0, b_busy}, 7'd1);
    tick();
    chk("busy_drop", {6'b0, b_busy}, 7'd0);
    found = 1'b0;
    for (int i = 0; i < 9 && !found; i++) begin
      tick();
      found = (dig === 6'b101111) && (disp === TENS0);
    end
    chk("return_tens_0", {6'b0, found}, 7'd1);
    wait_slot(6'b011111, D + 1, "return_ones_slot");
    chk("return_ones_5", disp, 7'b0010010);

    $display("[TB] expiry collision");
    b_val = 7'd88;
    b_req = 1'b1;
    tick();
    acc   = n;
    b_req = 1'b0;
    while (n < acc + 19) tick();
    b_req = 1'b1;
    b_val = 7'd3;
    tick();
    b_req = 1'b0;
    chk("collision_ack", {6'b0, b_ack}, 7'd1);
    chk("collision_busy", {6'b0, b_busy}, 7'd1);
    acc   = n;
    found = 1'b0;
    for (int i = 0; i < 3 * D + 1 && !found; i++) begin
      tick();
      found = (dig === 6'b011111) && (disp === 7'b0110000);
    end
    chk("collision_shows_3", {6'b0, found}, 7'd1);
    while (n < acc + 19) tick();
    chk("collision_busy_hold", {6'b0, b_busy}, 7'd1);
    tick();
    chk("collision_busy_drop", {6'b0, b_busy}, 7'd0);

    $display("[TB] out of range and leading zero");
    a_val = 7'd100;
    repeat (2 * D + 2) tick();
    wait_slot(6'b101111, 2 * D, "dash100_tens_slot");
    chk("dash100_tens", disp, 7'b0111111);
    wait_slot(6'b011111, D + 1, "dash100_ones_slot");
    chk("dash100_ones", disp, 7'b0111111);
    a_val = 7'd127;
    repeat (2 * D + 2) tick();
    wait_slot(6'b101111, 2 * D, "dash127_tens_slot");
    chk("dash127_tens", disp, 7'b0111111);
    wait_slot(6'b011111, D + 1, "dash127_ones_slot");
    chk("dash127_ones", disp, 7'b0111111);
    a_val = 7'd7;
    repeat (2 * D + 2) tick();
    wait_slot(6'b101111, 2 * D, "seven_tens_slot");
    chk("seven_tens", disp, TENS0);
    wait_slot(6'b011111, D + 1, "seven_ones_slot");
    chk("seven_ones", disp, 7'b1111000);

    $display("[TB] reset during overlay");
    b_val = 7'd55;
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    tick();
    reset = 1'b1;
    b_req = 1'b1;
    tick();
    chk("reset_ovl_ack", {6'b0, b_ack}, 7'd0);
    chk("reset_ovl_busy", {6'b0, b_busy}, 7'd0);
    tick();
    reset = 1'b0;
    b_req = 1'b0;

    $display("[TB] randomized run");
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) a_val = 7'($urandom_range(0, 127));
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = int'($urandom_range(1, 5));
      if (burst > 0) begin
        b_req = 1'b1;
        b_val = 7'($urandom_range(0, 127));
        burst--;
      end else begin
        b_req = 1'b0;
        b_val = 7'($urandom_range(0, 127));
      end
      tick();
    end
    b_req = 1'b0;
    repeat (HOLD + 2 * D + 2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
